// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the pipeline MEM stage and the debug read path.
// The pipeline has fixed priority; a starvation counter forces one debug slot, stalling the pipeline for that cycle.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [DATA_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_valid,
    input  logic              d_req,
    input  logic [DATA_W-1:0] d_addr,
    output logic              d_busy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_PEND   = 2'd1,
        D_ISSUED = 2'd2,
        D_DONE   = 2'd3
    } d_state_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    d_state_t          d_state_r;
    d_state_t          d_state_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic [CNT_W-1:0]  starve_cnt_s;
    logic [DATA_W-1:0] d_addr_r;
    logic [DATA_W-1:0] d_addr_s;
    logic              d_grant_s;
    logic              d_forced_s;
    logic              d_capture_s;
    logic              p_grant_s;
    logic [DATA_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] last_addr_r;
    logic [DATA_W-1:0] last_wdata_r;
    logic              p_tag_r;
    logic              p_valid_r;
    logic [DATA_W-1:0] p_rdata_r;
    logic              d_valid_r;
    logic              d_busy_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Debug FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_state_r    <= D_IDLE;
            starve_cnt_r <= {CNT_W{1'b0}};
            d_addr_r     <= {DATA_W{1'b0}};
        end else begin
            d_state_r    <= d_state_s;
            starve_cnt_r <= starve_cnt_s;
            d_addr_r     <= d_addr_s;
        end
    end

    // Debug FSM next state, grant decision and starvation counting
    always_comb begin
        d_state_s    = d_state_r;
        starve_cnt_s = starve_cnt_r;
        d_addr_s     = d_addr_r;
        d_grant_s    = 1'b0;
        d_forced_s   = 1'b0;
        d_capture_s  = 1'b0;
        case (d_state_r)
            D_IDLE: begin
                if (d_req) begin
                    d_addr_s  = d_addr;
                    d_state_s = D_PEND;
                end else begin
                    d_state_s = D_IDLE;
                end
            end
            D_PEND: begin
                d_forced_s = (starve_cnt_r == STARVE_LIM);
                if (!p_req || d_forced_s) begin
                    d_grant_s    = 1'b1;
                    starve_cnt_s = {CNT_W{1'b0}};
                    d_state_s    = D_ISSUED;
                end else if (starve_cnt_r < STARVE_LIM) begin
                    starve_cnt_s = starve_cnt_r + CNT_ONE;
                end else begin
                    starve_cnt_s = STARVE_LIM;
                end
            end
            D_ISSUED: begin
                d_capture_s = 1'b1;
                d_state_s   = D_DONE;
            end
            D_DONE: begin
                // d_req is deliberately ignored here so a held request cannot retrigger early
                d_state_s = D_IDLE;
            end
            default: begin
                d_state_s = D_IDLE;
            end
        endcase
    end

    // Memory port grant mux; an idle port keeps presenting the last address
    always_comb begin
        mem_addr_s  = last_addr_r;
        mem_wdata_s = last_wdata_r;
        mem_we_s    = 1'b0;
        p_grant_s   = 1'b0;
        if (d_grant_s) begin
            mem_addr_s = d_addr_r;
        end else if (p_req) begin
            mem_addr_s  = p_addr;
            mem_wdata_s = p_wdata;
            mem_we_s    = p_we;
            p_grant_s   = 1'b1;
        end else begin
            mem_addr_s = last_addr_r;
        end
    end

    // Held port values, read tag and returned data for both requesters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_addr_r  <= {DATA_W{1'b0}};
            last_wdata_r <= {DATA_W{1'b0}};
            p_tag_r      <= 1'b0;
            p_valid_r    <= 1'b0;
            p_rdata_r    <= {DATA_W{1'b0}};
            d_valid_r    <= 1'b0;
            d_busy_r     <= 1'b0;
            d_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            last_addr_r  <= mem_addr_s;
            last_wdata_r <= mem_wdata_s;
            p_tag_r      <= p_grant_s & ~p_we;
            p_valid_r    <= p_tag_r;
            p_rdata_r    <= p_tag_r ? mem_rdata : p_rdata_r;
            d_valid_r    <= d_capture_s;
            d_busy_r     <= (d_state_s == D_PEND) || (d_state_s == D_ISSUED);
            d_rdata_r    <= d_capture_s ? mem_rdata : d_rdata_r;
        end
    end

    assign p_stall   = d_forced_s & p_req;
    assign p_rdata   = p_rdata_r;
    assign p_valid   = p_valid_r;
    assign d_busy    = d_busy_r;
    assign d_rdata   = d_rdata_r;
    assign d_valid   = d_valid_r;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign mem_we    = mem_we_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against an event-time reference model and a 64-word memory.
module tb_dmem_arbiter;

    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          p_req = 1'b0;
    logic          p_we = 1'b0;
    logic [DW-1:0] p_addr = 32'h0;
    logic [DW-1:0] p_wdata = 32'h0;
    logic          p_stall;
    logic [DW-1:0] p_rdata;
    logic          p_valid;
    logic          d_req = 1'b0;
    logic [DW-1:0] d_addr = 32'h0;
    logic          d_busy;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata = 32'h0;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_W(DW), .STARVE_MAX(SMAX), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata), .p_valid(p_valid),
        .d_req(d_req), .d_addr(d_addr), .d_busy(d_busy), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory with a bench-side preload port
    logic [DW-1:0] mem [0:63];
    logic          load_en = 1'b0;
    logic [5:0]    load_idx = 6'd0;
    logic [DW-1:0] load_val = 32'h0;
    always @(posedge clock) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: debug transaction tracked by acceptance/grant cycle numbers
    typedef struct { int c; logic [31:0] d; } pexp_t;
    pexp_t       pq[$];
    logic [31:0] shadow [0:63];
    int          cyc = 0;
    bit          dbg_open;
    int          acc_c, gnt_c, lost;
    logic [31:0] dbg_addr, dbg_data;
    logic [31:0] last_addr, exp_p_rdata, exp_d_rdata;

    function automatic int idx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    task automatic model_clear();
        pq.delete();
        dbg_open = 1'b0; acc_c = 0; gnt_c = -1; lost = 0;
        dbg_addr = 32'h0; dbg_data = 32'h0;
        last_addr = 32'h0; exp_p_rdata = 32'h0; exp_d_rdata = 32'h0;
    endtask

    task automatic step(input bit preq, input bit pwe, input logic [31:0] paddr, input logic [31:0] pwdata,
                        input bit dreq, input logic [31:0] daddr);
        bit pending, forced, dgrant, e_busy, e_dv, e_pv, e_we, was_open;
        logic [31:0] e_addr;
        @(posedge clock); #1;
        p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwdata; d_req = dreq; d_addr = daddr;
        pending = dbg_open && gnt_c < 0 && cyc > acc_c;
        forced  = pending && lost == SMAX;
        dgrant  = pending && (!preq || forced);
        e_busy  = dbg_open && cyc > acc_c && (gnt_c < 0 || cyc <= gnt_c + 1);
        e_dv    = dbg_open && gnt_c >= 0 && cyc == gnt_c + 2;
        e_pv    = pq.size() > 0 && pq[0].c == cyc;
        e_we    = !dgrant && preq && pwe;
        e_addr  = dgrant ? dbg_addr : (preq ? paddr : last_addr);
        if (e_pv) begin exp_p_rdata = pq[0].d; void'(pq.pop_front()); end
        if (e_dv) exp_d_rdata = dbg_data;
        @(negedge clock);
        check("p_stall", 32'(p_stall), 32'(forced && preq));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, pwdata);
        check("p_valid", 32'(p_valid), 32'(e_pv));
        check("p_rdata", p_rdata, exp_p_rdata);
        check("d_busy", 32'(d_busy), 32'(e_busy));
        check("d_valid", 32'(d_valid), 32'(e_dv));
        check("d_rdata", d_rdata, exp_d_rdata);
        was_open = dbg_open;
        if (dgrant) begin gnt_c = cyc; dbg_data = shadow[idx(dbg_addr)]; end
        else if (pending) lost++;
        if (e_dv) dbg_open = 1'b0;
        if (!was_open && dreq) begin
            dbg_open = 1'b1; acc_c = cyc; gnt_c = -1; lost = 0; dbg_addr = daddr;
        end
        if (preq && !dgrant) begin
            if (pwe) shadow[idx(paddr)] = pwdata;
            else pq.push_back('{cyc + 2, shadow[idx(paddr)]});
        end
        last_addr = e_addr;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge
    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b0;
        p_req = 1'b0; p_we = 1'b0; d_req = 1'b0;
        #1;
        check("rst_d_busy", 32'(d_busy), 32'h0);
        check("rst_d_valid", 32'(d_valid), 32'h0);
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_p_stall", 32'(p_stall), 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_p_rdata", p_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        model_clear();
        @(posedge clock); #3;
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clock);
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            load_en = 1'b1; load_idx = 6'(i);
            load_val = (i == 4) ? 32'h12345678 : $urandom;
            shadow[i] = load_val;
        end
        @(negedge clock); load_en = 1'b0;
        do_reset();

        // Write then read back, then three back-to-back reads
        step(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
        idle(3);
        step(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0);
        idle(3);

        // Uncontended debug read
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
        idle(5);

        // Starvation: pipeline requests every cycle
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h10);
        for (int i = 0; i < 9; i++) step(1'b1, 1'(i % 2), 32'(i * 4 + 32'h40), $urandom, 1'b0, 32'h0);
        idle(3);

        // Debug request held high across completions
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h14);
        idle(4);

        // Reset while the debug read is issued
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        do_reset();
        idle(5);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom,
                 $urandom_range(0, 3) == 0, $urandom);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between two requesters: the pipeline MEM stage (stage registers EX_MEM to MEM_WB) and the debug read path that feeds data_select and the LCD.
- The pipeline has fixed priority. A starvation counter forces a debug slot after STARVE_MAX lost cycles; in that cycle the arbiter stalls the pipeline.
- The block sits between EX_MEM outputs, data_memory and data_select, and returns read data to each requester with a valid pulse.

Parameters:
- DATA_W, 32, data and address width.
- STARVE_MAX, 4, number of consecutive cycles a pending debug read may lose to the pipeline before it is forced (range 1..255).
- CNT_W, 8, width of the starvation counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- p_req  in  1  pipeline requests a memory access this cycle.
- p_we  in  1  pipeline access is a write (qualified by p_req).
- p_addr  in  DATA_W  pipeline address.
- p_wdata  in  DATA_W  pipeline write data.
- p_stall  out  1  pipeline access refused this cycle; the pipeline holds and retries.
- p_rdata  out  DATA_W  pipeline read data, registered.
- p_valid  out  1  one-cycle pulse: p_rdata is fresh.
- d_req  in  1  debug read request; sampled only while d_busy=0.
- d_addr  in  DATA_W  debug address; captured with d_req.
- d_busy  out  1  a debug read is in flight.
- d_rdata  out  DATA_W  debug read data; holds its value until the next debug completion.
- d_valid  out  1  one-cycle pulse: d_rdata is fresh.
- mem_addr  out  DATA_W  address to data_memory.
- mem_wdata  out  DATA_W  write data to data_memory.
- mem_we  out  1  write enable to data_memory.
- mem_rdata  in  DATA_W  data_memory output; valid in the cycle after the address is presented.

Behaviour:
- Reset (reset=0, asynchronous) clears the following, and the same clearing applies mid-operation, so an in-flight read produces no valid pulse after reset releases:
  - p_rdata, d_rdata, the starvation counter and all tags reset to 0.
  - p_valid, d_valid, d_busy and p_stall reset to 0.
  - The debug FSM goes to D_IDLE.
- Debug FSM:
  - D_IDLE: if d_req=1, latch d_addr and go to D_PEND. d_busy=1 from the next cycle.
  - D_PEND: granted if p_req=0, or if starve_cnt==STARVE_MAX. On grant go to D_ISSUED and clear starve_cnt. Otherwise stay in D_PEND and increment starve_cnt, saturating at STARVE_MAX.
  - D_ISSUED: capture mem_rdata into d_rdata and go to D_DONE.
  - D_DONE: d_valid=1 for this cycle only, d_busy=0, then go to D_IDLE. A d_req arriving in D_DONE is not sampled.
- Grant mux (combinational from state and inputs):
  - Debug grant: mem_addr=latched debug address, mem_we=0.
  - Forced debug grant while p_req=1: additionally p_stall=1.
  - Otherwise, when p_req=1: mem_addr=p_addr, mem_wdata=p_wdata, mem_we=p_we, p_stall=0.
  - Idle: mem_we=0, and mem_addr holds the last driven value.
- Pipeline read tag:
  - A granted read (p_req=1, p_we=0, p_stall=0) sets a tag.
  - Next cycle: mem_rdata is captured into p_rdata.
  - The cycle after that: p_valid=1. Total latency from grant to p_valid is 2 cycles.
  - Back-to-back reads pipeline at one per cycle.
- Writes produce no p_valid. A write refused by p_stall never reaches memory.
- p_stall is asserted for exactly one cycle per forced slot. The pipeline is never stalled for more than 1 of every STARVE_MAX+1 cycles.
- Debug is read-only; data_memory is never written from d_*.
- Address width is passed through unchanged; the arbiter performs no truncation or alignment.

Test Plan:
- Reset while idle, then release → all outputs 0. p_req=1, p_we=1, p_addr=0x8, p_wdata=0xDEADBEEF → mem_we=1 and mem_addr=0x8 the same cycle, no p_valid, p_stall=0.
- Pipeline read p_addr=0x8 in cycle N, memory returns 0xDEADBEEF → p_rdata=0xDEADBEEF and p_valid=1 in cycle N+2 only. Reads at 0x4, 0x8, 0xC on consecutive cycles → three consecutive p_valid pulses, data in order.
- p_req=0, d_req=1, d_addr=0x10 (memory holds 0x12345678) → d_busy=1 next cycle, issue, d_rdata=0x12345678 with d_valid pulse 3 cycles after d_req, then d_busy=0.
- p_req held 1 continuously, d_req at cycle 0 with STARVE_MAX=4 → debug loses 4 cycles, forced on the 5th pending cycle with p_stall=1 and mem_we=0 for that single cycle. The pipeline access that cycle does not reach memory, and p_req continues uninterrupted afterwards.
- d_req held high through completion → exactly one d_valid per completion, and no new request is latched in D_DONE.
- Reset asserted in D_ISSUED → d_busy=0 immediately, no d_valid after release, d_rdata=0.
